// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM port arbiter: FSM states, owner
// selects and the muxed memory request record.
package vram_arb_pkg;

  typedef enum logic [2:0] {
    CPU_OWN = 3'd0,
    TURN_V  = 3'd1,
    TURN_B  = 3'd2,
    VPU_OWN = 3'd3,
    BLT_OWN = 3'd4,
    TURN_C  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OWN_CPU  = 2'd0,
    OWN_VPU  = 2'd1,
    OWN_BLT  = 2'd2,
    OWN_NONE = 2'd3
  } owner_e;

  localparam int BLT_BURST_DEF   = 16;
  localparam int CPU_SLOT_DEF    = 4;
  localparam int WDOG_CYCLES_DEF = 1023;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        cs;
    logic        we;
  } mem_req_t;

endpackage

// File: rtl/vram_arb_mux.sv
// Combinational owner-to-memory-port mux; OWN_NONE parks the port at all zeros.
module vram_arb_mux
  import vram_arb_pkg::*;
(
  input  owner_e   owner,
  input  mem_req_t cpu,
  input  mem_req_t vpu,
  input  mem_req_t blt,
  output mem_req_t mem
);

  always_comb begin
    mem = '0;
    case (owner)
      OWN_CPU: mem = cpu;
      OWN_VPU: mem = vpu;
      OWN_BLT: mem = blt;
      default: mem = '0;
    endcase
  end

endmodule

// File: rtl/vram_arbiter.sv
// Three-way arbiter (VPU > blitter > CPU) for the single VRAM port.
// Optional ownership watchdog enabled by defining ARB_WATCHDOG_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int BLT_BURST   = BLT_BURST_DEF,
  parameter int CPU_SLOT    = CPU_SLOT_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  input  logic        cpu_cs,
  output logic        cpu_halt,
  input  logic        vpu_hold,
  input  logic [15:0] vpu_addr,
  input  logic        vpu_cs,
  output logic        vpu_grant,
  input  logic        blt_req,
  input  logic [15:0] blt_addr,
  input  logic [7:0]  blt_wdata,
  input  logic        blt_we,
  output logic        blt_grant,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_cs,
  output logic        mem_we,
  output logic        arb_err
);

  localparam int BW = $clog2(BLT_BURST + 1);
  localparam int SW = $clog2(CPU_SLOT + 1);

  state_e        state, state_nx;
  logic [BW-1:0] burst_cnt, burst_nx;
  logic [SW-1:0] slot_cnt;
  logic          load_slot;
  logic          vpu_req, blt_rq;   // requests after watchdog masking
  logic          wdog_hit;
  logic          cpu_halt_q, vpu_grant_q, blt_grant_q;
  owner_e        owner;
  mem_req_t      cpu_s, vpu_s, blt_s, mem_s;

  always_comb begin
    state_nx  = state;
    burst_nx  = burst_cnt;
    load_slot = 1'b0;
    case (state)
      CPU_OWN: begin
        if (vpu_req)                     state_nx = TURN_V;
        else if (blt_rq && slot_cnt == '0) state_nx = TURN_B;
      end
      TURN_V: state_nx = VPU_OWN;
      TURN_B: state_nx = BLT_OWN;
      VPU_OWN: begin
        if (wdog_hit)     state_nx = TURN_C;
        else if (!vpu_req) state_nx = blt_rq ? TURN_B : TURN_C;
      end
      BLT_OWN: begin
        // Preemption leaves the burst count untouched so the resumed burst
        // only gets the remainder of its budget.
        if (vpu_req) begin
          state_nx = TURN_V;
        end else if (wdog_hit || !blt_rq) begin
          state_nx = TURN_C;
          burst_nx = '0;
        end else if (burst_cnt == BW'(BLT_BURST - 1)) begin
          state_nx  = TURN_C;
          burst_nx  = '0;
          load_slot = 1'b1;
        end else begin
          burst_nx = burst_cnt + 1'b1;
        end
      end
      TURN_C:  state_nx = vpu_req ? TURN_V : CPU_OWN;
      default: state_nx = CPU_OWN;
    endcase
  end

  // The slot also counts down through TURN_C, so the CPU sees exactly
  // CPU_SLOT cycles in CPU_OWN before the blitter is re-admitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CPU_OWN;
      burst_cnt   <= '0;
      slot_cnt    <= '0;
      cpu_halt_q  <= 1'b0;
      vpu_grant_q <= 1'b0;
      blt_grant_q <= 1'b0;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
      if (load_slot)           slot_cnt <= SW'(CPU_SLOT);
      else if (slot_cnt != '0) slot_cnt <= slot_cnt - 1'b1;
      cpu_halt_q  <= (state_nx != CPU_OWN);
      vpu_grant_q <= (state_nx == VPU_OWN);
      blt_grant_q <= (state_nx == BLT_OWN);
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] own_cnt;
  logic          vpu_mask, blt_mask, err_q;
  logic          revoke_v, revoke_b;

  assign wdog_hit = (own_cnt == WW'(WDOG_CYCLES - 1));
  assign revoke_v = wdog_hit && state == VPU_OWN;
  assign revoke_b = wdog_hit && state == BLT_OWN && !vpu_req;
  assign vpu_req  = vpu_hold & ~vpu_mask;
  assign blt_rq   = blt_req & ~blt_mask;
  assign arb_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      own_cnt  <= '0;
      vpu_mask <= 1'b0;
      blt_mask <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if ((state == VPU_OWN || state == BLT_OWN) && state_nx == state)
        own_cnt <= own_cnt + 1'b1;
      else
        own_cnt <= '0;
      if (revoke_v)      vpu_mask <= 1'b1;
      else if (!vpu_hold) vpu_mask <= 1'b0;
      if (revoke_b)      blt_mask <= 1'b1;
      else if (!blt_req) blt_mask <= 1'b0;
      err_q <= err_q | revoke_v | revoke_b;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign vpu_req  = vpu_hold;
  assign blt_rq   = blt_req;
  assign arb_err  = 1'b0;
`endif

  assign cpu_halt  = cpu_halt_q;
  assign vpu_grant = vpu_grant_q;
  assign blt_grant = blt_grant_q & ~vpu_req;

  // A preempted blitter is parked off the port so no write lands while
  // its grant is low.
  always_comb begin
    owner = OWN_NONE;
    case (state)
      CPU_OWN: owner = OWN_CPU;
      VPU_OWN: owner = OWN_VPU;
      BLT_OWN: if (!vpu_req) owner = OWN_BLT;
      default: owner = OWN_NONE;
    endcase
  end

  assign cpu_s = {cpu_addr, cpu_wdata, cpu_cs, cpu_cs & ~cpu_rw};
  assign vpu_s = {vpu_addr, 8'h00, vpu_cs, 1'b0};
  assign blt_s = {blt_addr, blt_wdata, blt_we | blt_req, blt_we};

  vram_arb_mux u_mux (
    .owner (owner),
    .cpu   (cpu_s),
    .vpu   (vpu_s),
    .blt   (blt_s),
    .mem   (mem_s)
  );

  assign mem_addr  = mem_s.addr;
  assign mem_wdata = mem_s.wdata;
  assign mem_cs    = mem_s.cs;
  assign mem_we    = mem_s.we;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single external video/system memory port and shares it among three requesters: the CPU, the VPU line-fetch DMA (hold/vramcs handshake) and a block-copy/blitter engine.
- Muxes address, write data and control onto the memory port and stalls the CPU while a DMA owns the bus.
- Guarantees the VPU its real-time line fetch and bounds blitter bursts so the CPU is never starved.

Parameters:
- BLT_BURST, 16: maximum consecutive blitter-owned cycles before a forced CPU window.
- CPU_SLOT, 4: cycles the CPU keeps the bus after a blitter burst expires.
- WDOG_CYCLES, 1023: watchdog limit on continuous ownership; used only with ARB_WATCHDOG_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rw  in  1  1=read, 0=write
- cpu_cs  in  1  CPU memory select
- cpu_halt  out  1  CPU stall (clock-enable low)
- vpu_hold  in  1  VPU bus request
- vpu_addr  in  16  VPU DMA address
- vpu_cs  in  1  VPU memory select (vramcs)
- vpu_grant  out  1  VPU owns the bus
- blt_req  in  1  blitter bus request
- blt_addr  in  16  blitter address
- blt_wdata  in  8  blitter write data
- blt_we  in  1  blitter write strobe
- blt_grant  out  1  blitter owns the bus
- mem_addr  out  16  memory address
- mem_wdata  out  8  memory write data
- mem_cs  out  1  memory select
- mem_we  out  1  memory write enable
- arb_err  out  1  watchdog revoke flag, sticky until rst; tied 0 when ARB_WATCHDOG_EN is absent

Behaviour:
- Reset values: state CPU_OWN; cpu_halt=0; vpu_grant=0; blt_grant=0; arb_err=0; counters 0.
- Memory port: mem_* are a combinational mux of the current owner's signals, gated to 0 in TURN.
- CPU owner: mem_cs=cpu_cs, mem_we=cpu_cs & ~cpu_rw.
- VPU owner: mem_cs=vpu_cs, mem_we=0 (read only).
- Blitter owner: mem_cs=blt_we|blt_req, mem_we=blt_we.
- Priority: VPU > blitter > CPU. Fixed priority, no round-robin.
- State CPU_OWN:
  - vpu_hold=1: next state TURN_V, cpu_halt=1 registered. The VPU waits 2 cycles between hold and vramcs, so ownership reaches the VPU in 2 cycles.
  - else blt_req=1 and slot counter is 0: next state TURN_B, cpu_halt=1.
  - Slot counter decrements each cycle while >0.
- State TURN_V / TURN_B:
  - 1-cycle bus turnaround; mem_cs=0.
  - Moves to VPU_OWN / BLT_OWN; the matching grant is registered high on entry.
- State VPU_OWN:
  - Held while vpu_hold=1.
  - On vpu_hold=0: go to TURN_C, then CPU_OWN. If blt_req=1, go directly to TURN_B instead (CPU stays halted).
- State BLT_OWN:
  - Burst counter increments each cycle.
  - vpu_hold=1 preempts: blt_grant drops the same cycle (combinationally), then TURN_V. The burst counter keeps its value.
  - blt_req=0: TURN_C, burst counter cleared.
  - Burst counter reaches BLT_BURST-1: TURN_C, burst counter cleared, slot counter loaded with CPU_SLOT.
  - The blitter must stall while blt_grant=0 and may not assume any access completed in a cycle where the grant was low.
- State TURN_C:
  - mem_cs=0. cpu_halt is released (registered 0) on the transition into CPU_OWN.
  - vpu_hold seen in TURN_C goes to TURN_V; cpu_halt stays 1.
- Simultaneous vpu_hold and blt_req in CPU_OWN: VPU wins. The blitter is served after the VPU releases, even within a CPU slot; the slot counter applies only from CPU_OWN.
- vpu_hold dropping in TURN_V: complete the turnaround to VPU_OWN, then release next cycle.
- Reset mid-DMA: all grants and cpu_halt drop the next edge, state CPU_OWN. Requesters must re-request.

Optional Feature:
- Macro ARB_WATCHDOG_EN.
- With it: an owner counter runs in VPU_OWN/BLT_OWN. When it hits WDOG_CYCLES, the grant is forcibly revoked: TURN_C, arb_err=1 (sticky), and that requester is masked until its request drops low for at least 1 cycle.
- Without it: no counter, arb_err tied 0, ownership unbounded for the VPU.

Decomposition:
- Shared package vram_arb_pkg:
  - state enum (CPU_OWN, TURN_V, TURN_B, VPU_OWN, BLT_OWN, TURN_C), 3-bit encoding;
  - owner-select constants OWN_CPU/OWN_VPU/OWN_BLT;
  - default BLT_BURST/CPU_SLOT values.
- One natural sub-module: vram_arb_mux, the purely combinational owner-to-memory-port mux. The FSM and counters stay in the top.

Test Plan:
- Reset → cpu_halt=0, grants=0, mem_addr follows cpu_addr. CPU write at 0x1234 → mem_we=1, mem_addr=0x1234.
- vpu_hold rises at cycle T:
  - cpu_halt=1 at T+1;
  - vpu_grant=1 and mem_addr=vpu_addr at T+2;
  - 40 vpu_cs reads → mem_we stays 0.
  - vpu_hold falls → cpu_halt=0 two cycles later.
- blt_req held high with BLT_BURST=16, CPU_SLOT=4 → blt_grant high 16 cycles, 1 turnaround, CPU_OWN for 4 cycles, then the blitter regains the bus. Repeats.
- Blitter owns the bus; vpu_hold rises → blt_grant=0 same cycle, vpu_grant=1 two cycles later; blitter resumes after the VPU releases with no CPU window in between.
- vpu_hold and blt_req rise in the same cycle from CPU_OWN → VPU granted first, blitter second, CPU released last.
- ARB_WATCHDOG_EN, WDOG_CYCLES=8, vpu_hold stuck high → grant revoked after 8 cycles, arb_err=1. The VPU stays masked until vpu_hold=0 for 1 cycle, then re-grant works and arb_err stays 1.
